// File: rtl/ahb_manager_arbiter.sv
// Two-manager AHB-Lite arbiter. A non-granted manager's NONSEQ is absorbed into a
// one-entry hold buffer and replayed once the bus is handed over; bursts are never split.

module ahb_manager_arbiter_hold #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic         clr,
  input  logic [W-1:0] live,
  output logic [W-1:0] held,
  output logic         pend
);
  logic [W-1:0] held_q, held_d;
  logic         pend_q, pend_d;

  always_comb begin
    held_d = held_q;
    pend_d = pend_q;
    if (cap) begin
      held_d = live;
      pend_d = 1'b1;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      pend_q <= 1'b0;
    end else begin
      held_q <= held_d;
      pend_q <= pend_d;
    end
  end

  assign held = held_q;
  assign pend = pend_q;
endmodule

module ahb_manager_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [2*ADDR_WIDTH-1:0] M_HADDR,
  input  logic [3:0]              M_HTRANS,
  input  logic [1:0]              M_HWRITE,
  input  logic [5:0]              M_HSIZE,
  input  logic [5:0]              M_HBURST,
  input  logic [2*DATA_WIDTH-1:0] M_HWDATA,
  output logic [1:0]              M_HREADY,
  output logic [3:0]              M_HRESP,
  output logic [DATA_WIDTH-1:0]   M_HRDATA,
  output logic [ADDR_WIDTH-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic                    HREADY,
  input  logic [1:0]              HRESP,
  input  logic [DATA_WIDTH-1:0]   HRDATA
);
  localparam int HW = ADDR_WIDTH + 9;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic [1:0][HW-1:0] live, held;
  logic [1:0]         pend, mready, cap, clr;
  logic [HW-1:0]      bus;
  logic [1:0]         bus_trans;
  logic               g_q, g_d, lock_q, lock_d, d_q, d_d, dv_q, dv_d;
  logic [4:0]         cnt_q, cnt_d;

  for (genvar m = 0; m < 2; m++) begin : g_mgr
    localparam logic MI = (m == 1);
    assign live[m] = {M_HADDR[m*ADDR_WIDTH +: ADDR_WIDTH], M_HTRANS[2*m +: 2],
                      M_HWRITE[m], M_HSIZE[3*m +: 3], M_HBURST[3*m +: 3]};
    // A manager only sees the subordinate's HREADY when it owns the address or data phase.
    assign mready[m] = !HRESETn ? 1'b1 :
                       pend[m]  ? 1'b0 :
                       ((dv_q && d_q == MI) || g_q == MI) ? HREADY : 1'b1;
    assign cap[m] = (g_q != MI) && mready[m] && (M_HTRANS[2*m +: 2] == NONSEQ);
    assign clr[m] = (g_q == MI) && HREADY;
    assign M_HRESP[2*m +: 2] = (dv_q && d_q == MI) ? HRESP : 2'b00;

    ahb_manager_arbiter_hold #(.W(HW)) u_hold (
      .clk(HCLK), .rst_n(HRESETn), .cap(cap[m]), .clr(clr[m]),
      .live(live[m]), .held(held[m]), .pend(pend[m])
    );
  end

  assign bus = pend[g_q] ? held[g_q] : live[g_q];
  assign {HADDR, bus_trans, HWRITE, HSIZE, HBURST} = bus;
  assign HTRANS   = HRESETn ? bus_trans : IDLE;
  assign HWDATA   = (dv_q && d_q) ? M_HWDATA[DATA_WIDTH +: DATA_WIDTH] : M_HWDATA[DATA_WIDTH-1:0];
  assign M_HRDATA = HRDATA;
  assign M_HREADY = mready;

  always_comb begin
    g_d    = g_q;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    dv_d   = dv_q;
    if (HREADY) begin
      d_d  = g_q;
      dv_d = HTRANS[1];
      case (HTRANS)
        IDLE: lock_d = 1'b0;
        BUSY: lock_d = lock_q;
        NONSEQ: begin
          lock_d = (HBURST != 3'b000);
          case (HBURST)
            3'b010, 3'b011: cnt_d = 5'd3;
            3'b100, 3'b101: cnt_d = 5'd7;
            3'b110, 3'b111: cnt_d = 5'd15;
            default:        cnt_d = cnt_q;
          endcase
        end
        SEQ: begin
          if (HBURST == 3'b001) begin
            lock_d = 1'b1;
          end else if (HBURST != 3'b000) begin
            if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
            if (cnt_d == 5'd0) lock_d = 1'b0;
          end
        end
        default: lock_d = lock_q;
      endcase
      // Hand over only once the current owner's burst has released the lock.
      if (pend[~g_q] && !lock_d) g_d = ~g_q;
    end else if (HRESP == 2'b01) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g_q    <= 1'b0;
      lock_q <= 1'b0;
      cnt_q  <= 5'd0;
      d_q    <= 1'b0;
      dv_q   <= 1'b0;
    end else begin
      g_q    <= g_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      dv_q   <= dv_d;
    end
  end
endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// Directed scenarios followed by random traffic; every cycle is compared against a
// request/owner level model of the arbiter kept in the bench.

module tb_ahb_manager_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [63:0] M_HADDR, M_HWDATA;
  logic [3:0]  M_HTRANS, M_HRESP;
  logic [1:0]  M_HWRITE, M_HREADY, HTRANS, HRESP;
  logic [5:0]  M_HSIZE, M_HBURST;
  logic [31:0] M_HRDATA, HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  logic [31:0] maddr[2], mwdata[2];
  logic [1:0]  mtrans[2];
  logic        mwrite[2];
  logic [2:0]  msize[2], mburst[2];

  assign M_HADDR  = {maddr[1], maddr[0]};
  assign M_HWDATA = {mwdata[1], mwdata[0]};
  assign M_HTRANS = {mtrans[1], mtrans[0]};
  assign M_HWRITE = {mwrite[1], mwrite[0]};
  assign M_HSIZE  = {msize[1], msize[0]};
  assign M_HBURST = {mburst[1], mburst[0]};

  ahb_manager_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
    .M_HRDATA(M_HRDATA), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int errs = 0, checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
  } req_t;

  // Model: who owns the bus, who has a request parked, who owns the data phase (-1 none),
  // and how many fixed-burst beats remain.
  req_t hbuf[2];
  bit   waiting[2];
  int   owner, dphase, cnt;
  bit   lock;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t live_of(int m);
    req_t r;
    r.addr = maddr[m]; r.trans = mtrans[m]; r.write = mwrite[m];
    r.size = msize[m]; r.burst = mburst[m];
    return r;
  endfunction

  function automatic req_t cur_src();
    return waiting[owner] ? hbuf[owner] : live_of(owner);
  endfunction

  function automatic logic m_ready(int m);
    if (!HRESETn) return 1'b1;
    if (waiting[m]) return 1'b0;
    if (dphase == m || owner == m) return HREADY;
    return 1'b1;
  endfunction

  task automatic model_reset();
    owner = 0; dphase = -1; cnt = 0; lock = 0;
    waiting[0] = 0; waiting[1] = 0;
  endtask

  task automatic model_step();
    req_t s = cur_src();
    logic [1:0] r = {m_ready(1), m_ready(0)};
    bit wn[2];
    wn[0] = waiting[0]; wn[1] = waiting[1];
    for (int m = 0; m < 2; m++) begin
      req_t l = live_of(m);
      if (owner != m && r[m] && l.trans == 2'b10) begin
        wn[m] = 1; hbuf[m] = l;
      end else if (owner == m && HREADY) begin
        wn[m] = 0;
      end
    end
    if (HREADY) begin
      dphase = s.trans[1] ? owner : -1;
      case (s.trans)
        2'b00: lock = 0;
        2'b10: begin
          if (s.burst == 3'd0) lock = 0;
          else if (s.burst == 3'd1) lock = 1;
          else begin
            lock = 1;
            cnt = (4 << ((int'(s.burst) - 2) / 2)) - 1;
          end
        end
        2'b11: begin
          if (s.burst == 3'd1) lock = 1;
          else if (s.burst != 3'd0) begin
            if (cnt > 0) cnt--;
            if (cnt == 0) lock = 0;
          end
        end
        default: ;
      endcase
      if (waiting[1-owner] && !lock) owner = 1 - owner;
    end else if (HRESP == 2'b01) begin
      lock = 0;
    end
    waiting[0] = wn[0]; waiting[1] = wn[1];
  endtask

  task automatic half();
    req_t s;
    @(negedge HCLK);
    s = cur_src();
    chk("HADDR", HADDR, s.addr);
    chk("HTRANS", HTRANS, HRESETn ? s.trans : 2'b00);
    chk("HWRITE", HWRITE, s.write);
    chk("HSIZE", HSIZE, s.size);
    chk("HBURST", HBURST, s.burst);
    chk("M_HREADY", M_HREADY, {m_ready(1), m_ready(0)});
    chk("M_HRESP", M_HRESP, {(dphase == 1) ? HRESP : 2'b00, (dphase == 0) ? HRESP : 2'b00});
    chk("HWDATA", HWDATA, (dphase == 1) ? mwdata[1] : mwdata[0]);
    chk("M_HRDATA", M_HRDATA, HRDATA);
  endtask

  task automatic adv();
    @(posedge HCLK);
    if (!HRESETn) model_reset(); else model_step();
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic set_m(int m, logic [1:0] t, logic [2:0] b, logic [31:0] a);
    maddr[m] = a; mtrans[m] = t; mburst[m] = b; mwrite[m] = 1'b1; msize[m] = 3'd2;
  endtask

  int n0, n1;

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h1234_5678;
    set_m(0, 2'b00, 3'd0, 32'h0); set_m(1, 2'b00, 3'd0, 32'h0);
    mwdata[0] = 32'h0; mwdata[1] = 32'h0;
    model_reset();
    #1;
    chk("rst_hready", M_HREADY, 2'b11);
    chk("rst_hresp", M_HRESP, 4'b0000);
    chk("rst_htrans", HTRANS, 2'b00);
    cyc(); cyc();
    HRESETn = 1'b1;

    // Single write from M0, M1 idle
    set_m(0, 2'b10, 3'd0, 32'h4);
    half();
    chk("s_addr", HADDR, 32'h4); chk("s_ready_a", M_HREADY, 2'b11);
    adv();
    set_m(0, 2'b00, 3'd0, 32'h0); mwdata[0] = 32'hA5;
    half();
    chk("s_wdata", HWDATA, 32'hA5); chk("s_ready_d", M_HREADY, 2'b11);
    adv();

    // M0 INCR4, M1 NONSEQ during beat 2
    set_m(0, 2'b10, 3'd3, 32'h0); cyc();
    set_m(0, 2'b11, 3'd3, 32'h4); set_m(1, 2'b10, 3'd0, 32'h8); cyc();
    set_m(0, 2'b11, 3'd3, 32'h8); set_m(1, 2'b00, 3'd0, 32'h0);
    half(); chk("b4_wait_c", M_HREADY[1], 1'b0); adv();
    set_m(0, 2'b11, 3'd3, 32'hC);
    half(); chk("b4_wait_d", M_HREADY[1], 1'b0); chk("b4_beat4", HADDR, 32'hC); adv();
    set_m(0, 2'b00, 3'd0, 32'h0);
    half(); chk("b4_m1_addr", HADDR, 32'h8); chk("b4_m1_trans", HTRANS, 2'b10);
    chk("b4_wait_e", M_HREADY[1], 1'b0); adv();
    half(); chk("b4_m1_done", M_HREADY[1], 1'b1); adv();
    cyc();

    // Both managers stream SINGLEs
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      set_m(0, 2'b10, 3'd0, 32'h100); set_m(1, 2'b10, 3'd0, 32'h200);
      half();
      if (HADDR == 32'h100) n0++;
      if (HADDR == 32'h200) n1++;
      adv();
    end
    chk("fair_m0", n0, 4); chk("fair_m1", n1, 4);
    set_m(0, 2'b00, 3'd0, 32'h0); set_m(1, 2'b00, 3'd0, 32'h0);
    cyc(); cyc(); cyc();

    // M1 INCR8 with error on beat 3, M0 pending
    set_m(1, 2'b10, 3'd5, 32'h40); set_m(0, 2'b10, 3'd0, 32'h80); cyc();
    set_m(0, 2'b00, 3'd0, 32'h0);
    set_m(1, 2'b11, 3'd5, 32'h44); cyc();
    set_m(1, 2'b11, 3'd5, 32'h48); cyc();
    set_m(1, 2'b11, 3'd5, 32'h4C); HREADY = 1'b0; HRESP = 2'b01;
    half(); chk("err_resp1", M_HRESP, 4'b0100); chk("err_ready1", M_HREADY, 2'b00); adv();
    set_m(1, 2'b00, 3'd0, 32'h0); HREADY = 1'b1;
    half(); chk("err_resp2", M_HRESP, 4'b0100); chk("err_ready2", M_HREADY[1], 1'b1); adv();
    HRESP = 2'b00;
    half(); chk("err_m0_addr", HADDR, 32'h80); chk("err_m0_trans", HTRANS, 2'b10);
    chk("err_m0_wait", M_HREADY[0], 1'b0); adv();
    cyc(); cyc();

    // Wait states during M0 burst while M1 is pending
    set_m(0, 2'b10, 3'd3, 32'h100); set_m(1, 2'b10, 3'd0, 32'h300); cyc();
    set_m(1, 2'b00, 3'd0, 32'h0);
    set_m(0, 2'b11, 3'd3, 32'h104); cyc();
    set_m(0, 2'b11, 3'd3, 32'h108); HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half(); chk("ws_addr", HADDR, 32'h108); chk("ws_ready", M_HREADY, 2'b00); adv();
    end
    HREADY = 1'b1; cyc();
    set_m(0, 2'b11, 3'd3, 32'h10C); cyc();
    set_m(0, 2'b00, 3'd0, 32'h0);
    half(); chk("ws_m1_addr", HADDR, 32'h300); adv();
    cyc(); cyc();

    // Reset in the middle of an INCR16
    set_m(1, 2'b10, 3'd7, 32'h500); set_m(0, 2'b10, 3'd0, 32'h600); cyc();
    set_m(0, 2'b00, 3'd0, 32'h0);
    set_m(1, 2'b11, 3'd7, 32'h504); cyc();
    set_m(1, 2'b11, 3'd7, 32'h508);
    HRESETn = 1'b0; model_reset(); #1;
    chk("mr_ready", M_HREADY, 2'b11); chk("mr_trans", HTRANS, 2'b00);
    half(); adv();
    HRESETn = 1'b1;
    set_m(1, 2'b00, 3'd0, 32'h0); set_m(0, 2'b10, 3'd0, 32'h700);
    half(); chk("mr_m0_addr", HADDR, 32'h700); chk("mr_m0_trans", HTRANS, 2'b10);
    chk("mr_m0_ready", M_HREADY, 2'b11); adv();
    set_m(0, 2'b00, 3'd0, 32'h0); cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        maddr[m]  = $urandom;
        mtrans[m] = 2'($urandom_range(0, 3));
        mburst[m] = 3'($urandom_range(0, 7));
        mwrite[m] = 1'($urandom_range(0, 1));
        msize[m]  = 3'($urandom_range(0, 2));
        mwdata[m] = $urandom;
      end
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
      HRDATA = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        HRESETn = 1'b0; model_reset();
      end else begin
        HRESETn = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
